// File: rtl/filter_history_register_file.sv
// filter_history_register_file: per-slot history of the last NUM_TAPS samples with pipelined pushes and a clear sweep
// Ports: i_Clock/i_Reset clock and async active-high reset; i_Clear starts a zeroing sweep, o_Busy while it runs;
// i_WriteEnable/i_WriteAddress/i_WriteData push a sample, o_WriteDropped flags a push refused while busy;
// i_ReadAddress/o_ReadData give NUM_READ_PORTS registered reads of all taps of a slot (tap1 in index 0).
module filter_history_register_file #(
  parameter int DATA_WIDTH     = 16,
  parameter int ADDR_WIDTH     = 8,
  parameter int NUM_TAPS       = 2,
  parameter int NUM_READ_PORTS = 3
) (
  input  logic                                                          i_Clock,
  input  logic                                                          i_Reset,
  input  logic                                                          i_Clear,
  output logic                                                          o_Busy,
  input  logic                                                          i_WriteEnable,
  input  logic [ADDR_WIDTH-1:0]                                         i_WriteAddress,
  input  logic signed [DATA_WIDTH-1:0]                                  i_WriteData,
  output logic                                                          o_WriteDropped,
  input  logic [NUM_READ_PORTS-1:0][ADDR_WIDTH-1:0]                     i_ReadAddress,
  output logic signed [NUM_READ_PORTS-1:0][NUM_TAPS-1:0][DATA_WIDTH-1:0] o_ReadData
);
  localparam int DEPTH = 2**ADDR_WIDTH;
  typedef enum logic {IDLE, CLEAR} state_t;
  typedef logic [NUM_TAPS-1:0][DATA_WIDTH-1:0] taps_t;
  state_t                state_q;
  logic [ADDR_WIDTH-1:0] cnt_q;
  logic                  p_valid_q;
  logic [ADDR_WIDTH-1:0] p_addr_q;
  taps_t                 p_taps_q;
  taps_t                 p_taps_d;
  taps_t                 old_taps;
  taps_t                 mem_q [DEPTH];
  assign o_Busy = state_q == CLEAR;
  // A push to the slot still waiting in stage 2 must shift from the uncommitted taps.
  always_comb begin
    old_taps = (p_valid_q && p_addr_q == i_WriteAddress) ? p_taps_q : mem_q[i_WriteAddress];
    p_taps_d = old_taps;
    p_taps_d[0] = i_WriteData;
    for (int k = 1; k < NUM_TAPS; k++) p_taps_d[k] = old_taps[k-1];
  end
  always_ff @(posedge i_Clock or posedge i_Reset) begin
    if (i_Reset) begin
      state_q        <= CLEAR;
      cnt_q          <= '0;
      p_valid_q      <= 1'b0;
      o_WriteDropped <= 1'b0;
      o_ReadData     <= '0;
    end else begin
      o_WriteDropped <= i_WriteEnable && o_Busy;
      // A push coinciding with an accepted clear is swallowed by the sweep, not reported as dropped.
      p_valid_q      <= i_WriteEnable && !o_Busy && !i_Clear;
      for (int p = 0; p < NUM_READ_PORTS; p++) o_ReadData[p] <= mem_q[i_ReadAddress[p]];
      if (i_Clear) begin
        state_q <= CLEAR;
        cnt_q   <= '0;
      end else if (o_Busy) begin
        cnt_q   <= cnt_q + 1'b1;
        state_q <= (cnt_q == ADDR_WIDTH'(DEPTH-1)) ? IDLE : CLEAR;
      end
    end
  end
  // Storage and stage-2 payload carry no reset; validity alone gates the commit.
  always_ff @(posedge i_Clock) begin
    p_addr_q <= i_WriteAddress;
    p_taps_q <= p_taps_d;
    if (o_Busy) mem_q[cnt_q] <= '0;
    else if (p_valid_q && !i_Clear) mem_q[p_addr_q] <= p_taps_q;
  end
endmodule

// File: tb/tb_filter_history_register_file.sv
module tb_filter_history_register_file;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic clr = 1'b0;
  logic busy;
  logic we = 1'b0;
  logic [7:0] wa = '0;
  logic signed [15:0] wd = '0;
  logic dropped;
  logic [2:0][7:0] ra = '0;
  logic signed [2:0][1:0][15:0] rd;
  int vectors = 0;
  int miscompares = 0;
  logic signed [15:0] m [256][2];
  logic [15:0] exp_rd [3][2];
  logic idle_ph = 1'b0;
  logic p1_v = 1'b0, p2_v = 1'b0;
  logic [7:0] p1_a, p2_a;
  logic signed [15:0] p1_d, p2_d;
  typedef struct {
    logic we;
    logic [7:0] wa;
    logic signed [15:0] wd;
    logic [7:0] ra;
    logic signed [15:0] e1;
    logic signed [15:0] e2;
  } vec_t;
  vec_t tbl[$];
  filter_history_register_file dut (
    .i_Clock(clk), .i_Reset(rst), .i_Clear(clr), .o_Busy(busy),
    .i_WriteEnable(we), .i_WriteAddress(wa), .i_WriteData(wd), .o_WriteDropped(dropped),
    .i_ReadAddress(ra), .o_ReadData(rd)
  );
  always #5 clk = ~clk;
  task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask
  task automatic model_zero();
    for (int s = 0; s < 256; s++) begin
      m[s][0] = '0;
      m[s][1] = '0;
    end
    p1_v = 1'b0;
    p2_v = 1'b0;
  endtask
  // A push sampled at edge E is seen by reads sampled at E+2 onward.
  task automatic step();
    @(posedge clk);
    #1;
    if (p2_v) begin
      m[p2_a][1] = m[p2_a][0];
      m[p2_a][0] = p2_d;
    end
    for (int p = 0; p < 3; p++) begin
      exp_rd[p][0] = m[ra[p]][0];
      exp_rd[p][1] = m[ra[p]][1];
    end
    p2_v = p1_v; p2_a = p1_a; p2_d = p1_d;
    p1_v = we && idle_ph; p1_a = wa; p1_d = wd;
  endtask
  task automatic chk_all(input string nm);
    for (int p = 0; p < 3; p++) begin
      chk(nm, rd[p][0], exp_rd[p][0]);
      chk(nm, rd[p][1], exp_rd[p][1]);
    end
  endtask
  task automatic chk_zero(input string nm);
    for (int p = 0; p < 3; p++) begin
      chk(nm, rd[p][0], 16'h0);
      chk(nm, rd[p][1], 16'h0);
    end
  endtask
  task automatic busy_len(input string nm, input int want);
    int n;
    n = 0;
    while (busy && n < 1000) begin
      step();
      n++;
    end
    chk(nm, 16'(n), 16'(want));
  endtask
  task automatic add(input logic w, input logic [7:0] a, input logic signed [15:0] d,
                     input logic [7:0] r, input logic signed [15:0] e1, input logic signed [15:0] e2);
    tbl.push_back('{w, a, d, r, e1, e2});
  endtask
  initial begin
    int a;
    model_zero();
    add(1, 5, 16'sh0100, 5, 0, 0);
    add(0, 0, 0, 5, 0, 0);
    add(0, 0, 0, 5, 16'sh0100, 0);
    add(1, 5, 16'sh0200, 5, 16'sh0100, 0);
    add(1, 5, 16'sh0300, 5, 16'sh0100, 0);
    add(0, 0, 0, 5, 16'sh0200, 16'sh0100);
    add(0, 0, 0, 5, 16'sh0300, 16'sh0200);
    add(1, 7, 1, 7, 0, 0);
    add(1, 7, 2, 7, 0, 0);
    add(1, 7, 3, 7, 1, 0);
    add(1, 8, 16'sh10, 7, 2, 1);
    add(1, 7, 4, 7, 3, 2);
    add(1, 8, 16'sh11, 8, 16'sh10, 0);
    add(1, 7, 5, 7, 4, 3);
    add(0, 0, 0, 8, 16'sh11, 16'sh10);
    add(0, 0, 0, 7, 5, 4);
    add(1, 9, 16'sh7FFF, 9, 0, 0);
    add(0, 0, 0, 9, 0, 0);
    add(0, 0, 0, 9, 16'sh7FFF, 0);
    add(1, 255, 16'sh1234, 255, 0, 0);
    add(1, 255, 16'sh5678, 0, 0, 0);
    add(0, 0, 0, 255, 16'sh1234, 0);
    add(0, 0, 0, 255, 16'sh5678, 16'sh1234);
    add(1, 0, -16'sh8000, 0, 0, 0);
    add(0, 0, 0, 0, 0, 0);
    add(0, 0, 0, 0, -16'sh8000, 0);
    // Reset state, then the power-up sweep.
    step();
    step();
    chk("rst_busy", 16'(busy), 16'h1);
    chk("rst_dropped", 16'(dropped), 16'h0);
    chk_zero("rst_rd");
    rst = 1'b0;
    busy_len("sweep_len", 256);
    ra = {8'd255, 8'd128, 8'd0};
    step();
    chk_zero("post_sweep_rd");
    // Directed table on all three ports at the same address.
    idle_ph = 1'b1;
    foreach (tbl[i]) begin
      we = tbl[i].we; wa = tbl[i].wa; wd = tbl[i].wd;
      ra = {3{tbl[i].ra}};
      step();
      for (int p = 0; p < 3; p++) begin
        chk($sformatf("tbl%0d_t1", i), rd[p][0], tbl[i].e1);
        chk($sformatf("tbl%0d_t2", i), rd[p][1], tbl[i].e2);
      end
    end
    // Random pushes and reads over a small slot set to provoke collisions.
    for (int i = 0; i < 300; i++) begin
      we = 1'($urandom_range(0, 1));
      a = $urandom_range(0, 8);
      wa = (a == 8) ? 8'd255 : 8'(a);
      wd = 16'($urandom);
      for (int p = 0; p < 3; p++) begin
        a = $urandom_range(0, 8);
        ra[p] = (a == 8) ? 8'd255 : 8'(a);
      end
      step();
      chk_all("rand_rd");
      chk("rand_dropped", 16'(dropped), 16'h0);
    end
    // Clear with a concurrent push, a push mid-sweep, and a restart at cycle 100.
    idle_ph = 1'b0;
    clr = 1'b1; we = 1'b1; wa = 8'd3; wd = 16'sh2222;
    step();
    clr = 1'b0; we = 1'b0;
    chk("clr_busy", 16'(busy), 16'h1);
    chk("clr_accept_nodrop", 16'(dropped), 16'h0);
    for (int k = 1; k < 10; k++) step();
    we = 1'b1; wa = 8'd3; wd = 16'sh3333;
    step();
    we = 1'b0;
    chk("drop_pulse", 16'(dropped), 16'h1);
    step();
    chk("drop_once", 16'(dropped), 16'h0);
    for (int k = 12; k < 100; k++) step();
    chk("busy_at_99", 16'(busy), 16'h1);
    clr = 1'b1;
    step();
    clr = 1'b0;
    busy_len("restart_len", 256);
    model_zero();
    ra = {8'd255, 8'd7, 8'd3};
    step();
    chk_zero("post_clear_rd");
    ra = {8'd9, 8'd5, 8'd0};
    step();
    chk_zero("post_clear_rd2");
    // Reset hitting a push in flight.
    idle_ph = 1'b1;
    we = 1'b1; wa = 8'd3; wd = 16'sh4444; ra = {3{8'd3}};
    step();
    we = 1'b0;
    step();
    step();
    we = 1'b1; wd = 16'sh5555;
    step();
    we = 1'b0;
    chk_all("pre_reset_rd");
    rst = 1'b1;
    #1;
    chk_zero("reset_async_rd");
    chk("reset_async_busy", 16'(busy), 16'h1);
    step();
    step();
    rst = 1'b0;
    idle_ph = 1'b0;
    model_zero();
    busy_len("reset_sweep_len", 256);
    step();
    chk_zero("post_reset_slot3");
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/filter_history_register_file.md
FILTER_HISTORY_REGISTER_FILE -- requirements
Module: filter_history_register_file

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 16: signed sample width.
REQ-002 SHALL have parameter ADDR_WIDTH, default 8: history slots, DEPTH = 2**ADDR_WIDTH, one slot per operator.
REQ-003 SHALL have parameter NUM_TAPS, default 2, legal 1..4: past samples kept per slot, tap1 = x[n-1] ... tapK = x[n-K].
REQ-004 SHALL have parameter NUM_READ_PORTS, default 3: independent read ports.
REQ-005 SHALL have port i_Clock, input, 1: the single clock; all state updates on its rising edge.
REQ-006 SHALL have port i_Reset, input, 1: asynchronous, active-high reset.
REQ-007 SHALL have port i_Clear, input, 1: one-cycle request to zero all history.
REQ-008 SHALL have port o_Busy, output, 1: clear sweep in progress.
REQ-009 SHALL have port i_WriteEnable, input, 1: push a new sample.
REQ-010 SHALL have port i_WriteAddress, input, ADDR_WIDTH: slot to push into.
REQ-011 SHALL have port i_WriteData, input, signed DATA_WIDTH: new sample x[n].
REQ-012 SHALL have port o_WriteDropped, output, 1: one-cycle pulse when a push is rejected.
REQ-013 SHALL have port i_ReadAddress, input, NUM_READ_PORTS x ADDR_WIDTH: per-port read slot.
REQ-014 SHALL have port o_ReadData, output, NUM_READ_PORTS x NUM_TAPS x signed DATA_WIDTH: registered taps per port.

Function
REQ-015 SHALL, on a push sampled at edge E, shift the slot: tap1 <= i_WriteData, tapk <= tap(k-1), tapK discarded.
REQ-016 SHALL implement the push as a 2-stage pipeline: stage 1 at E latches address/data and reads old taps; stage 2 commits at E+1.
REQ-017 SHALL forward stage-2 results to stage 1 when consecutive pushes target the same slot, so no tap is lost or duplicated.
REQ-018 SHALL accept one push per cycle, back-to-back, with no stall.
REQ-019 SHALL register reads: address sampled at edge R gives o_ReadData valid after R, held until the next edge.
REQ-020 SHALL make a read sampled at E or E+1 return the pre-push taps, and one at E+2 or later return the post-push taps; no read forwarding.
REQ-021 SHALL serve all read ports independently; identical addresses on several ports return identical data.
REQ-022 SHALL run an FSM with states IDLE and CLEAR; IDLE->CLEAR on i_Clear or reset; CLEAR->IDLE after slot DEPTH-1 is zeroed.
REQ-023 SHALL, in CLEAR, zero all taps of one slot per cycle, counter ascending 0..DEPTH-1; sweep takes exactly DEPTH cycles; o_Busy = (state == CLEAR).
REQ-024 SHALL restart the sweep at slot 0 when i_Clear arrives while busy.
REQ-025 SHALL ignore pushes sampled while o_Busy is high and pulse o_WriteDropped high for the following cycle.
REQ-026 SHALL cancel a stage-2 commit in flight at the edge where a clear is accepted; it is not counted as dropped.
REQ-027 SHALL leave read data during CLEAR undefined per slot, each slot holding old or zero; reads stay legal.
REQ-028 SHALL handle address wrap with no special case; slot DEPTH-1 behaves like any other.

Reset
REQ-029 SHALL, on i_Reset assertion, immediately force state=CLEAR, counter=0, o_Busy=1, o_WriteDropped=0, o_ReadData all zero, and pipeline valid=0.
REQ-030 SHALL hold that state while i_Reset is high and start sweeping on the first edge after release; storage arrays need no reset.
REQ-031 SHALL discard any push in flight when reset hits mid-operation.

Verification
REQ-032 SHALL cover: release reset (DEPTH=256) -> o_Busy high 256 cycles then low; reads of slots 0, 128, 255 return all taps 0.
REQ-033 SHALL cover: pushes 0x0100, 0x0200, 0x0300 to slot 5 with idle gaps -> read slot 5 = {tap1 0x0300, tap2 0x0200}.
REQ-034 SHALL cover: back-to-back pushes 1, 2, 3 to slot 7 on consecutive cycles -> slot 7 = {3, 2}; interleaved 7/8/7 pushes keep both slots correct.
REQ-035 SHALL cover: push 0x7FFF to slot 9 at E, read slot 9 on all 3 ports at E, E+1, E+2 -> E and E+1 show old taps, E+2 shows tap1 0x7FFF on every port.
REQ-036 SHALL cover: i_Clear, then a push at cycle 10 of the sweep -> o_WriteDropped pulses once; second i_Clear at cycle 100 -> o_Busy stays high 256 more cycles.
REQ-037 SHALL cover: i_Reset asserted the cycle after a push to slot 3 -> push lost, o_ReadData zero at once, slot 3 reads 0 after the sweep.
